// File: rtl/seg_pkg.sv
// Shared types and hex decode for the seven-segment display controller.
// Pattern layout: bit7..bit1 = segments a..g, bit0 = decimal point (active-high here).
package seg_pkg;

  localparam int NUM_DIGITS = 8;

  typedef struct packed {
    logic       blank;
    logic       dp;
    logic [3:0] val;
  } digit_t;

  localparam logic [7:0] HEX_PATTERN [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
  };

  // A blanked digit is fully dark, decimal point included.
  function automatic logic [7:0] seg_encode(input digit_t d);
    logic [7:0] pat;
    pat = HEX_PATTERN[d.val] | {7'b0, d.dp};
    if (d.blank) pat = 8'h00;
    return pat;
  endfunction

endpackage

// File: rtl/seg_rr_arb.sv
// Two-requester round-robin arbiter; req[0]/gnt[0] is writer A, req[1]/gnt[1] is writer B.
// Grants are combinational; the last-grant pointer moves only when something is granted.
module seg_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // Set when B was granted most recently; reset value makes A win the first contention.
  logic last_b;

  always_comb begin
    gnt[0] = req[0] & (~req[1] | last_b);
    gnt[1] = req[1] & (~req[0] | ~last_b);
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_b <= 1'b1;
    end else if (gnt[0]) begin
      last_b <= 1'b0;
    end else if (gnt[1]) begin
      last_b <= 1'b1;
    end
  end

endmodule

// File: rtl/seg_display_ctrl.sv
// Eight-digit seven-segment controller shared by two valid/ready writers.
// Optional scrolling rotation is built only when SEG_DISPLAY_CTRL_SCROLL_EN is defined.
module seg_display_ctrl
  import seg_pkg::*;
#(
  parameter int CLK_NUM = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_valid,
  output logic       a_ready,
  input  logic [2:0] a_idx,
  input  logic [3:0] a_val,
  input  logic       a_dp,
  input  logic       a_blank,
  input  logic       b_valid,
  output logic       b_ready,
  input  logic [2:0] b_idx,
  input  logic [3:0] b_val,
  input  logic       b_dp,
  input  logic       b_blank,
  input  logic       scroll_on,
  output logic [7:0] o_seg0,
  output logic [7:0] o_seg1,
  output logic [7:0] o_seg2,
  output logic [7:0] o_seg3,
  output logic [7:0] o_seg4,
  output logic [7:0] o_seg5,
  output logic [7:0] o_seg6,
  output logic [7:0] o_seg7
);

  logic [1:0] gnt;
  logic       wr_en;
  logic [2:0] wr_idx;
  digit_t     wr_data;
  digit_t     digits [NUM_DIGITS];
  logic [7:0] seg_q  [NUM_DIGITS];
  logic [2:0] offset;

  seg_rr_arb u_arb (
    .clk (clk),
    .rst (rst),
    .req ({b_valid, a_valid}),
    .gnt (gnt)
  );

  assign a_ready = gnt[0];
  assign b_ready = gnt[1];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wr_en   = |gnt;
    wr_idx  = b_idx;
    wr_data = digit_t'{blank: b_blank, dp: b_dp, val: b_val};
    if (gnt[0]) begin
      wr_idx  = a_idx;
      wr_data = digit_t'{blank: a_blank, dp: a_dp, val: a_val};
    end
  end

  // NOTE: the digit file is reset explicitly because the display must come up dark.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digits[i] <= digit_t'{blank: 1'b1, dp: 1'b0, val: 4'h0};
      end
    end else if (wr_en) begin
      digits[wr_idx] <= wr_data;
    end
  end

`ifdef SEG_DISPLAY_CTRL_SCROLL_EN
  localparam int CNT_W = (CLK_NUM > 0) ? $clog2(CLK_NUM + 1) : 1;

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || !scroll_on) begin
      count  <= '0;
      offset <= '0;
    end else if (count == CNT_W'(CLK_NUM)) begin
      count  <= '0;
      offset <= offset + 3'd1;
    end else begin
      count <= count + 1'b1;
    end
  end
`else
  // Rotation hardware is absent; the scroll inputs are kept only for interface compatibility.
  logic unused_scroll;
  assign unused_scroll = scroll_on | (CLK_NUM == 0);
  assign offset        = 3'd0;
`endif

  // Output K shows digit (K + offset) mod 8; the 3-bit sum wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        seg_q[i] <= 8'hFF;
      end
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        seg_q[i] <= ~seg_encode(digits[3'(i) + offset]);
      end
    end
  end

  assign o_seg0 = seg_q[0];
  assign o_seg1 = seg_q[1];
  assign o_seg2 = seg_q[2];
  assign o_seg3 = seg_q[3];
  assign o_seg4 = seg_q[4];
  assign o_seg5 = seg_q[5];
  assign o_seg6 = seg_q[6];
  assign o_seg7 = seg_q[7];

endmodule

// File: doc/seg_display_ctrl.md
# seg_display_ctrl

Controller that owns the eight seven-segment digits and shares them between two independent writers. Each writer posts (digit index, hex value, decimal point, blank) updates over a valid/ready port; a round-robin arbiter accepts one update per cycle into an 8-entry digit register file. The block hex-decodes the digits and drives the active-low o_seg0..o_seg7 outputs. An optional timed rotation scrolls the digits across the display.

## Interface
- CLK_NUM, 500000: scroll tick period is CLK_NUM+1 clk cycles.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- a_valid  in  1  writer A has an update.
- a_ready  out  1  writer A granted this cycle. Combinational from both valids and the RR pointer.
- a_idx  in  3  target digit.
- a_val  in  4  hex value 0x0–0xF.
- a_dp  in  1  decimal point on.
- a_blank  in  1  digit fully dark.
- b_valid, b_ready, b_idx, b_val, b_dp, b_blank: same as the A ports, for writer B.
- scroll_on  in  1  enables rotation.
- o_seg0..o_seg7  out  8 each  registered, active-low pattern. Bit7..bit1 = segments a..g; bit0 = dp.

## Operation
- A write occurs when valid&ready. Digit register [idx] ← {blank, dp, val}.
- At most one write per cycle. Same-index conflicts therefore cannot occur within a cycle.
- Arbiter: 2-way round-robin.
  - Only one valid: that writer is granted.
  - Both valid: grant goes to the writer not granted most recently.
  - Pointer updates only on a grant.
  - After reset, A wins the first contention.
  - ready=0 when the corresponding valid=0.
- Writers must hold their fields stable while valid=1 and ready=0. valid must not depend on ready.
- Decode, with pattern = segs|dp:
  - 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0
  - 8=FE, 9=F6, A=EE, b=3E, C=9C, d=7A, E=9E, F=8E
- Output: o_segK = ~pattern(digit[(K+offset)&7]). If blank=1, pattern=0 (dp forced off as well), so the output is 8'hFF.
- Scroll counter:
  - When scroll_on=1: count runs 0..CLK_NUM. On count==CLK_NUM, count←0 and offset←offset+1 (3-bit wrap, 7→0).
  - When scroll_on=0: count←0 and offset←0.

## Timing
- Reset values:
  - All digit registers {blank=1, dp=0, val=0}.
  - o_seg0..7 = 8'hFF.
  - count=0, offset=0, RR pointer favours A.
- Write handshake in cycle N: digit register updated at the end of N; o_seg reflects it in cycle N+2. Fixed 2-cycle latency.
- Scroll: count==CLK_NUM in cycle M → offset changes at the end of M → o_seg changes in cycle M+2.
- A write and a scroll tick in the same cycle both take effect. Outputs in N+2 use the new offset and the new digit.
- rst mid-transfer discards any handshake in that cycle. ready is still combinational, but no write occurs while rst=1.
- Deasserting scroll_on mid-period resets offset to 0 on the next edge.

## Configuration
- SEG_DISPLAY_CTRL_SCROLL_EN defined: the scroll counter and offset logic are present as described.
- Undefined:
  - No counter or offset register; offset is constant 0.
  - scroll_on and CLK_NUM are kept in the interface but ignored.
  - o_segK always shows digit K.

## Structure
- Shared package seg_pkg holds:
  - NUM_DIGITS=8.
  - The digit_t struct {blank, dp, val[3:0]}.
  - The 16-entry hex-to-segment pattern constant array.
  - A seg_encode(digit_t) function returning the active-high pattern, with blank handling.
- Sub-module seg_rr_arb: 2-requester round-robin arbiter (req[1:0] → gnt[1:0], registered last-grant pointer, synchronous reset).
- Top-level contents: digit register file, scroll counter, output registers.

## Test plan
- Reset: hold rst 3 cycles → all o_seg = 8'hFF; a_ready = b_ready = 0 with valids low.
- Single write: A writes idx3, val 2, dp0 in cycle N → o_seg3 = 8'h25 from cycle N+2; the other outputs stay FF.
- Contention: both valid for 6 cycles with distinct idx → grant sequence A,B,A,B,A,B; each writer's fields held until granted.
- Ordering: A writes idx5 val 1, then B writes idx5 val 8 → final o_seg5 = 8'h01.
- Blank override: A writes idx0 val 8, dp1, blank1 → o_seg0 = 8'hFF.
- Scroll (CLK_NUM=3, macro defined): digits 0..7 loaded with val=idx, then scroll_on=1 → o_seg0 = 8'h03, then 8'h9F after one 4-cycle tick. After 8 ticks the display returns to offset 0. Dropping scroll_on restores o_seg0 = 8'h03 within 2 cycles.
